// File: rtl/bcd_to_unsigned.sv
// Sequential packed-BCD to unsigned binary converter.
// One decimal digit is folded in per cycle, most significant digit first,
// using acc*10 + digit. The trigger/idle/done handshake matches the
// display-side binary-to-BCD converter, so the two can be chained in a loopback.
module bcd_to_unsigned #(
    parameter int DIGITS = 8,
    parameter int OUT_W  = 27
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                trigger,
    input  logic [4*DIGITS-1:0] in,
    output logic                idle,
    output logic                done,
    output logic                error,
    output logic [OUT_W-1:0]    out
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    // Four spare bits let the multiply-accumulate run without intermediate
    // overflow. The result is truncated to OUT_W only when it is loaded into out.
    localparam int ACC_W = OUT_W + 4;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] sr_q, sr_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                inv_q, inv_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                err_q, err_d;
    logic                done_q, done_d;

    logic                in_bad;
    logic [3:0]          nib;
    logic [ACC_W-1:0]    acc_step;
    logic                last;

    // Flag the input if any nibble is not a decimal digit.
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (in[4*i +: 4] > 4'd9) in_bad = 1'b1;
        end
    end

    // One step of the conversion: acc*10 + the top digit, built from shifts.
    always_comb begin
        nib      = sr_q[4*DIGITS-1 -: 4];
        acc_step = (acc_q << 3) + (acc_q << 1) + ACC_W'(nib);
        last     = (cnt_q == CNT_W'(DIGITS - 1));
    end

    // Next-state and datapath update for the IDLE/CONVERT controller.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        out_d   = out_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    sr_d    = in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    inv_d   = in_bad;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                acc_d = acc_step;
                sr_d  = sr_q << 4;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    out_d   = inv_q ? '0 : acc_step[OUT_W-1:0];
                    err_d   = inv_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. Reset aborts any conversion in progress without a done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            out_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            out_q   <= out_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign idle  = (state_q == IDLE);
    assign done  = done_q;
    assign error = err_q;
    assign out   = out_q;

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Directed bench for bcd_to_unsigned with hand-computed expected results.
module tb_bcd_to_unsigned;

    localparam int DIGITS = 8;
    localparam int OUT_W  = 27;

    logic                clk;
    logic                reset;
    logic                trigger;
    logic [4*DIGITS-1:0] in_v;
    logic                idle;
    logic                done;
    logic                error;
    logic [OUT_W-1:0]    out_w;

    int nvec;
    int nerr;

    bcd_to_unsigned #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .trigger (trigger),
        .in      (in_v),
        .idle    (idle),
        .done    (done),
        .error   (error),
        .out     (out_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full conversion: pulse trigger, wait for done, then check the results.
    task automatic run(input string tag, input logic [31:0] bcd,
                       input logic [31:0] exp_out, input logic exp_err);
        int lat;
        lat = 0;
        in_v    = bcd;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk({tag, ".idle_low"}, {31'd0, idle}, 32'd0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, ".latency"}, lat, DIGITS);
        chk({tag, ".out"}, {5'd0, out_w}, exp_out);
        chk({tag, ".error"}, {31'd0, error}, {31'd0, exp_err});
        chk({tag, ".idle_done"}, {31'd0, idle}, 32'd1);
        tick();
        chk({tag, ".done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, ".out_hold"}, {5'd0, out_w}, exp_out);
    endtask

    initial begin
        int last_done;
        int ndone;
        nvec = 0;
        nerr = 0;
        reset   = 1'b0;
        trigger = 1'b0;
        in_v    = '0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst.idle", {31'd0, idle}, 32'd1);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.error", {31'd0, error}, 32'd0);
        chk("rst.out", {5'd0, out_w}, 32'd0);
        tick();

        run("c12345678", 32'h1234_5678, 32'h00BC_614E, 1'b0);
        run("c99999999", 32'h9999_9999, 32'h05F5_E0FF, 1'b0);
        run("c0", 32'h0000_0000, 32'h0000_0000, 1'b0);
        run("cbad", 32'h1234_A678, 32'h0000_0000, 1'b1);
        // The error flag must hold until the next conversion.
        tick();
        chk("bad.err_hold", {31'd0, error}, 32'd1);
        run("c42", 32'h0000_0042, 32'h0000_002A, 1'b0);

        // Trigger held high: one result every DIGITS+1 cycles, never back-to-back.
        in_v      = 32'h0000_0100;
        trigger   = 1'b1;
        last_done = -1;
        ndone     = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) begin
                chk("hold.out", {5'd0, out_w}, 32'h64);
                if (last_done >= 0) chk("hold.gap", c - last_done, DIGITS + 1);
                last_done = c;
                ndone++;
            end
        end
        trigger = 1'b0;
        chk("hold.count", ndone, 4);
        for (int c = 0; c < 12; c++) tick();

        // Changes to in and trigger during CONVERT must be ignored.
        in_v    = 32'h0000_0001;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        tick();
        in_v    = 32'h9999_9999;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int i = 4; i <= 7; i++) begin
            tick();
            chk("mid.no_early_done", {31'd0, done}, 32'd0);
        end
        tick();
        chk("mid.done", {31'd0, done}, 32'd1);
        chk("mid.out", {5'd0, out_w}, 32'd1);
        chk("mid.error", {31'd0, error}, 32'd0);
        tick();
        tick();
        chk("mid.no_restart", {31'd0, idle}, 32'd1);

        // Reset in the middle of a conversion: no done pulse and out cleared.
        in_v    = 32'h1234_5678;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort.idle", {31'd0, idle}, 32'd1);
        chk("abort.out", {5'd0, out_w}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort.no_done", ndone, 0);
        chk("abort.out_hold", {5'd0, out_w}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bcd_to_unsigned.md
Name: bcd_to_unsigned

Overview:
- Sequential BCD-to-binary converter. It is the inverse of the display path's binary-to-BCD stage.
- Takes a packed BCD value from the user-entry side (switch/keypad digit registers) and produces the unsigned binary equivalent for the ALU/datapath.
- Uses the same trigger/idle handshake as the display-side converter, so the two can be chained in a loopback.

Parameters:
- DIGITS, 8, number of BCD nibbles on the input.
- OUT_W, 27, binary output width. Must satisfy 2^OUT_W > 10^DIGITS - 1 (27 for 8 digits).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset.
- trigger  input  1  start request; sampled only while idle=1.
- in  input  4*DIGITS  packed BCD value; digit DIGITS-1 (most significant) in the top nibble.
- idle  output  1  high when ready to accept trigger.
- done  output  1  one-cycle pulse; out/error valid and updated.
- error  output  1  last conversion contained a nibble >9.
- out  output  OUT_W  binary result of last completed conversion.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE, idle=1, done=0, error=0, out=0, internal accumulator/shift register/counter cleared.
  - Reset overrides everything, including mid-conversion; an aborted conversion produces no done pulse and leaves out=0.
- FSM has two states, IDLE and CONVERT.
- IDLE:
  - idle=1.
  - If trigger=1 at edge T: latch in into shift register, acc=0, digit counter=0, flag invalid if any nibble >9, go to CONVERT.
  - idle=0 from edge T onward.
  - If trigger=0, stay in IDLE; outputs hold.
- CONVERT:
  - One digit per cycle, MSB first: acc <= acc*10 + top nibble, computed as (acc<<3)+(acc<<1)+nibble. Then shift register <<4 and counter+1.
  - Accumulator is OUT_W+4 bits internally; truncated to OUT_W when loaded to out.
  - On the DIGITS-th step (edge T+DIGITS):
    - out <= final acc, or 0 if the invalid flag is set.
    - error <= invalid flag.
    - done=1 for the cycle following edge T+DIGITS.
    - state returns to IDLE, so idle=1 in the same cycle as done.
- Latency: done and new out appear after edge T+DIGITS, i.e. DIGITS cycles after the trigger-sampling edge.
- Throughput: with trigger held high, the next trigger is sampled at edge T+DIGITS+1, giving one conversion every DIGITS+1 cycles (9 at default).
- trigger and in are ignored during CONVERT. The latched copy is used, so mid-conversion input changes have no effect.
- done never stays high 2 consecutive cycles.
- out and error hold their values between done pulses.
- error is cleared only by a subsequent valid conversion or by reset.
- Valid inputs never overflow OUT_W when the parameter rule holds. Other widths are unsupported configurations.

Test Plan:
- Reset, then in=0x12345678, trigger 1 cycle:
  - idle falls.
  - After 8 cycles done=1 for exactly one cycle, out=0x0BC614E (12345678), error=0, idle=1.
- in=0x99999999 → out=0x5F5E0FF, error=0. Then in=0x00000000 → out=0, error=0.
- in=0x1234A678 → done pulse with error=1, out=0. A following in=0x00000042 → out=0x2A, error=0.
- trigger tied to 1, in=0x00000100 → done every 9 cycles, out=0x64 each time, no back-to-back done.
- Change in from 0x00000001 to 0x99999999 and pulse trigger, both during CONVERT → result still out=1, no extra conversion started.
- Assert reset=0 at cycle 4 of a conversion of 0x12345678 → no done pulse, out=0, idle=1 on the cycle after release.
